sweep_channel_gen: RTL
======================

// Module: sweep_channel_gen
// PURPOSE
// Consumes the rising/falling direction flags of the velocity-drive slope detector and
//   turns them into Mossbauer sweep timing.
// Debounces the direction, detects each sweep start (falling->rising turn) and measures
//   the sweep period in clocks.
// Generates the time-binned channel index that downstream histogram/accumulator stages
//   use as their address. Runs in the slow_clk domain, directly after the slope detector.
// PARAMETERS
// N_CHANNELS  1024      channels per sweep; power of 2, >=4; CH_W = $clog2(N_CHANNELS)
// CH_CYCLES   16        slow_clk cycles per channel (dwell), >=1
// HOLD_CYCLES 4         consecutive samples needed to accept a direction change, >=1
// PERIOD_W    32        width of period counter/output
// TIMEOUT     16777216  cycles without sweep start before lock is dropped, < 2^PERIOD_W
// PORTS
// slow_clk       in   1         clock
// rst            in   1         asynchronous reset, active-high
// rising         in   1         upstream slope flag: signal increasing
// falling        in   1         upstream slope flag: signal decreasing
// sweep_start    out  1         1-cycle pulse at each accepted falling->rising turn
// period         out  PERIOD_W  clocks between last two sweep_start pulses
// period_valid   out  1         sticky; set at first period latch, cleared by reset/lock loss
// channel        out  CH_W      current channel index
// channel_valid  out  1         channel is meaningful (locked, not overflowed)
// ch_tick        out  1         1-cycle pulse when channel advances
// ch_overflow    out  1         sweep exceeded N_CHANNELS*CH_CYCLES; sticky to next sweep_start
// lock_lost      out  1         1-cycle pulse on timeout
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, all counters 0.
// - Candidate per cycle: UP = rising&!falling, DOWN = falling&!rising, else NONE.
//   Both set counts as NONE.
// - Debounce: counts consecutive cycles with the same candidate that differs from the
//   current direction. NONE or a changed candidate restarts the count.
// - Direction is accepted on the edge where that candidate has been sampled HOLD_CYCLES
//   times in a row.
// - FSM IDLE/RISE/FALL.
//   IDLE: accepted UP -> RISE. Pulse sweep_start; no period latch. DOWN ignored.
//   RISE: accepted DOWN -> FALL. No sweep_start.
//   FALL: accepted UP -> RISE. Pulse sweep_start; period <= pcnt+1; period_valid <= 1.
// - pcnt: cleared on every sweep_start edge, +1 per cycle in RISE/FALL, saturates at
//   all-ones. So period = cycles between consecutive sweep_start pulses.
// - Timeout: in RISE/FALL, when pcnt+1 == TIMEOUT:
//   state -> IDLE; lock_lost pulse; channel, pcnt, overflow and period_valid cleared.
//   period holds its last value.
// - Channel timing: on sweep_start, channel=0, prescaler=0, ch_overflow=0.
//   In RISE/FALL the prescaler counts 0..CH_CYCLES-1.
// - On prescaler wrap:
//   if channel < N_CHANNELS-1: channel+1 and ch_tick pulse;
//   else ch_overflow <= 1, channel holds, no tick.
// - channel_valid = (state != IDLE) && !ch_overflow, registered with channel.
// - sweep_start and a prescaler wrap in the same cycle: sweep_start wins (channel 0, no tick).
// - Outputs are registered; sweep_start rises on the same edge the state enters RISE.
// CONFIGURATION
// SWEEP_MIRROR_EN
//   Undefined: channel counts up monotonically across the whole sweep (both halves).
//   Defined: on the RISE->FALL turn, channel holds its value, then decrements on each
//     prescaler wrap during FALL (ch_tick pulses), saturating at 0 (no tick at 0).
//     This folds the spectrum.
//   ch_overflow is then only set during RISE.
// TESTING
// Bench parameters: N_CHANNELS=8, CH_CYCLES=4, HOLD_CYCLES=2, TIMEOUT=200.
// 1 Reset mid-sweep -> all outputs 0 immediately (asynchronous), state IDLE.
// 2 rising=1 for 2 cycles from IDLE -> sweep_start pulse on 2nd edge.
//   channel=0; ch_tick every 4 cycles; channel 1,2,3...
// 3 rising 20 cycles, falling 20, rising -> second sweep_start.
//   period=40, period_valid=1. Without macro, channel=7 reached with no overflow before the
//   turn... 40 cycles > 32: ch_overflow=1 and channel_valid=0 at cycle 32, cleared at
//   sweep_start.
// 4 Glitches: falling=1 single cycles, rising&falling=1 pairs -> no direction change,
//   no sweep_start.
// 5 Hold rising with no turn for 200 cycles -> lock_lost pulse, IDLE, period_valid=0,
//   channel_valid=0.
// 6 SWEEP_MIRROR_EN, rising 12 cycles then falling 12 -> channel 0..3 then 3,2,1,0,
//   holding at 0.

Source files
------------

// File: rtl/sweep_channel_gen.sv
// ---------------------------------------------------------------------------
// sweep_channel_gen
//
// Turns the rising/falling slope flags of the velocity-drive slope detector
// into Mossbauer sweep timing: a debounced drive direction, a pulse at every
// sweep start (falling->rising turn), the measured sweep period in slow_clk
// cycles, and the time-binned channel index used as the histogram address.
//
// Optional feature macro: SWEEP_MIRROR_EN
//   undefined : channel counts up across the whole sweep (both halves)
//   defined   : channel counts up during RISE, holds at the RISE->FALL turn,
//               then counts down during FALL, saturating at 0 (folded spectrum);
//               ch_overflow can then only be set during RISE.
//
// Ports
//   slow_clk      in   clock
//   rst           in   asynchronous reset, active-high
//   rising        in   upstream slope flag: signal increasing
//   falling       in   upstream slope flag: signal decreasing
//   sweep_start   out  1-cycle pulse at each accepted falling->rising turn
//   period        out  clocks between the last two sweep_start pulses
//   period_valid  out  sticky, set at first period latch, cleared on lock loss
//   channel       out  current channel index
//   channel_valid out  channel is meaningful (locked, not overflowed)
//   ch_tick       out  1-cycle pulse when channel changes
//   ch_overflow   out  sweep ran past N_CHANNELS*CH_CYCLES; sticky to next start
//   lock_lost     out  1-cycle pulse on sweep timeout
//   fsm_state     out  debug view of the FSM (0 IDLE, 1 RISE, 2 FALL)
//
// Output semantics: there is no back-pressure. channel is qualified by
// channel_valid and period by period_valid, both registered on the same edge
// as the value they qualify; sweep_start, ch_tick and lock_lost are
// single-cycle event strobes that the consumer must take when they are high.
// ---------------------------------------------------------------------------
module sweep_channel_gen #(
    parameter int N_CHANNELS  = 1024,
    parameter int CH_CYCLES   = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int PERIOD_W    = 32,
    parameter int TIMEOUT     = 16777216,
    localparam int CH_W       = $clog2(N_CHANNELS)
) (
    input  logic                slow_clk,
    input  logic                rst,
    input  logic                rising,
    input  logic                falling,
    output logic                sweep_start,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic [CH_W-1:0]     channel,
    output logic                channel_valid,
    output logic                ch_tick,
    output logic                ch_overflow,
    output logic                lock_lost,
    output logic [1:0]          fsm_state
);

    localparam int PS_W = (CH_CYCLES > 1) ? $clog2(CH_CYCLES) : 1;
    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(N_CHANNELS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;
    typedef enum logic [1:0] {C_NONE = 2'd0, C_UP = 2'd1, C_DOWN = 2'd2} cand_t;

    state_t              state;
    cand_t               cand;
    cand_t               cur_dir;
    cand_t               db_cand;
    logic [HC_W-1:0]     db_cnt;
    logic [HC_W-1:0]     db_next;
    logic [PS_W-1:0]     presc;
    logic [PERIOD_W-1:0] pcnt;
    logic [PERIOD_W:0]   pcnt_ext;

    logic cand_new;
    logic db_run;
    logic accept;
    logic start_sweep;
    logic turn_down;
    logic timeout;
    logic wrap;
    logic ch_inc;
    logic ch_dec;
    logic ovf_set;

    assign fsm_state = state;

    // Both flags set is treated as no information.
    always_comb begin
        cand = C_NONE;
        if (rising && !falling) begin
            cand = C_UP;
        end else if (falling && !rising) begin
            cand = C_DOWN;
        end
    end

    // In IDLE there is no current direction, so either candidate is "new".
    always_comb begin
        cur_dir = C_NONE;
        if (state == RISE) begin
            cur_dir = C_UP;
        end else if (state == FALL) begin
            cur_dir = C_DOWN;
        end
    end

    assign cand_new = (cand != C_NONE) && (cand != cur_dir);
    assign db_run   = (db_cnt != '0) && (cand == db_cand);
    assign db_next  = db_run ? db_cnt + HC_W'(1) : HC_W'(1);
    assign accept   = cand_new && (db_next == HC_W'(HOLD_CYCLES));

    // An accepted UP can only come from IDLE or FALL (in RISE, UP is not new).
    assign start_sweep = accept && (cand == C_UP);
    assign turn_down   = accept && (cand == C_DOWN) && (state == RISE);

    // Extra bit keeps pcnt+1 from wrapping when pcnt has saturated.
    assign pcnt_ext = {1'b0, pcnt} + (PERIOD_W + 1)'(1);
    assign timeout  = (state != IDLE) && (pcnt_ext == (PERIOD_W + 1)'(TIMEOUT));
    assign wrap     = (presc == PS_W'(CH_CYCLES - 1));

    always_comb begin
        ch_inc  = 1'b0;
        ch_dec  = 1'b0;
        ovf_set = 1'b0;
        if ((state != IDLE) && wrap) begin
`ifdef SWEEP_MIRROR_EN
            if (state == FALL) begin
                if (channel != '0) begin
                    ch_dec = 1'b1;
                end
            end else if (channel != CH_MAX) begin
                ch_inc = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
`else
            if (channel != CH_MAX) begin
                ch_inc = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            db_cand       <= C_NONE;
            db_cnt        <= '0;
            presc         <= '0;
            pcnt          <= '0;
            sweep_start   <= 1'b0;
            period        <= '0;
            period_valid  <= 1'b0;
            channel       <= '0;
            channel_valid <= 1'b0;
            ch_tick       <= 1'b0;
            ch_overflow   <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            sweep_start <= 1'b0;
            ch_tick     <= 1'b0;
            lock_lost   <= 1'b0;

            // Debounce restarts on NONE, on the current direction, and after
            // every acceptance (including a DOWN ignored in IDLE).
            db_cand <= cand;
            if (!cand_new || accept) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_next;
            end

            if (start_sweep) begin
                // Wins over a simultaneous prescaler wrap and over timeout.
                state         <= RISE;
                sweep_start   <= 1'b1;
                pcnt          <= '0;
                presc         <= '0;
                channel       <= '0;
                ch_overflow   <= 1'b0;
                channel_valid <= 1'b1;
                if (state == FALL) begin
                    period       <= pcnt_ext[PERIOD_W-1:0];
                    period_valid <= 1'b1;
                end
            end else if (timeout) begin
                // period keeps its last value for diagnostics.
                state         <= IDLE;
                lock_lost     <= 1'b1;
                pcnt          <= '0;
                presc         <= '0;
                channel       <= '0;
                ch_overflow   <= 1'b0;
                channel_valid <= 1'b0;
                period_valid  <= 1'b0;
            end else if (state != IDLE) begin
                if (turn_down) begin
                    state <= FALL;
                end
                if (pcnt != '1) begin
                    pcnt <= pcnt + PERIOD_W'(1);
                end
                if (wrap) begin
                    presc <= '0;
                end else begin
                    presc <= presc + PS_W'(1);
                end
                if (ch_inc) begin
                    channel <= channel + CH_W'(1);
                    ch_tick <= 1'b1;
                end else if (ch_dec) begin
                    channel <= channel - CH_W'(1);
                    ch_tick <= 1'b1;
                end
                if (ovf_set) begin
                    ch_overflow <= 1'b1;
                end
                channel_valid <= !(ch_overflow || ovf_set);
            end
        end
    end

endmodule
